pipe_stage_regs: RTL and testbench
==================================

Name: pipe_stage_regs

Overview:
- Parametrised, generic inter-stage pipeline register for the five-stage CPU; successor to the fixed-width, stall-only stage registers.
- Replaces the per-stage hand-wired dff banks with one block: a valid/ready handshake, a 2-entry skid buffer, synchronous flush (bubble insertion), a sticky halt tracker and a saturating back-pressure counter.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB with different widths.

Parameters:
- DATA_W, 16, width of each of the two data fields (ALU result, memory read data, PC, etc.)
- CTRL_W, 8, width of the control-bit bundle (MemToReg, RegWrite, LLB, LHB, ...)
- ADDR_W, 4, width of the destination register address
- CNT_W, 8, width of the stall-cycle counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- in_ctrl  input  CTRL_W  control bits of the beat
- in_data0  input  DATA_W  data field 0
- in_data1  input  DATA_W  data field 1
- in_waddr  input  ADDR_W  destination register address
- in_hlt  input  1  beat carries a halt instruction
- flush  input  1  squash all held beats
- out_valid  output  1  downstream beat valid
- out_ready  input  1  downstream accepts the beat
- out_ctrl  output  CTRL_W  control bits, forced to 0 when out_valid=0
- out_data0  output  DATA_W  data field 0
- out_data1  output  DATA_W  data field 1
- out_waddr  output  ADDR_W  destination register address
- out_hlt  output  1  head beat carries halt; gated by out_valid
- hlt_seen  output  1  sticky: a halt beat has been accepted downstream
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all storage and all outputs are 0, except in_ready=1.
- Handshake terms:
  - Upstream transfer: in_valid & in_ready at the clock edge.
  - Downstream transfer: out_valid & out_ready at the clock edge.
- Storage: main entry M drives the outputs; skid entry S.
  - in_ready is registered: in_ready = ~S.valid & ~hlt_seen.
- Latency: 1 cycle from upstream transfer to out_valid when M is empty or draining.
- Cases at each edge (flush=0):
  - M empty: incoming beat goes to M.
  - M full and downstream transfer: M ← S if S valid, else M ← incoming beat, else M empties.
  - M full, no downstream transfer, incoming beat: beat goes to S; in_ready drops next cycle.
  - Simultaneous transfers with S valid: M ← S, S ← incoming beat.
    - Not reachable: in_ready=0 whenever S is valid.
- Ordering: strictly FIFO. No beat is dropped or duplicated.
- Data fields hold their value while out_valid=0. Only out_ctrl and out_hlt are zero-gated.
- Flush (synchronous):
  - Clears M.valid, S.valid and the ctrl/hlt fields of both entries.
  - Takes priority over a simultaneous upstream transfer; that beat is discarded.
  - A downstream transfer in the same cycle still counts as completed.
  - in_ready=1 the next cycle, unless hlt_seen=1.
- Halt:
  - hlt_seen is set by a downstream transfer with out_hlt=1.
  - It stays set until reset; flush does not clear it.
  - While hlt_seen=1, in_ready=0 and no new beats are accepted. Beats already held still drain.
- Stall counter:
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1; does not wrap.
  - Not cleared by flush or by a downstream transfer; only reset clears it.
- Reset mid-operation: both entries invalidated immediately (asynchronous); outputs return to reset values within the same cycle.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined: 2-entry skid buffer as described above. in_ready is a pure register output, breaking the combinational ready path.
- Undefined:
  - Single entry M only; S is absent.
  - in_ready = (~out_valid | out_ready) & ~hlt_seen, combinational from out_ready.
  - Behaviour is otherwise identical, including flush, halt and stall_cnt.
  - Throughput stays 1 beat/cycle.

Test Plan:
- Reset then stream: in_valid=1 with in_data0=0x0001..0x0004, out_ready=1 → out_data0 shows 0x0001..0x0004 on consecutive cycles, 1-cycle latency, in_ready constantly 1.
- Back-pressure: send 0xAAAA, 0xBBBB; hold out_ready=0 for 3 cycles → skid holds 0xBBBB, in_ready=0 (SKID_EN), stall_cnt=3. Release → 0xAAAA then 0xBBBB, no loss.
- Flush with in_valid=1, in_ctrl=0xFF, M and S full → next cycle out_valid=0, out_ctrl=0x00, in_ready=1, flushed beats never appear.
- Halt: beat with in_hlt=1, then another beat, out_ready=1 → hlt_seen=1 after the halt transfer, in_ready=0 and stays 0 through a subsequent flush.
- Saturation: CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles → stall_cnt=15, holds at 15.
- Async reset asserted mid-stall with both entries full → out_valid=0, stall_cnt=0 and in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_stage_regs.sv
// -----------------------------------------------------------------------------
// pipe_stage_regs
//
// Generic inter-stage pipeline register for the five-stage CPU. One instance
// sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB); widths are
// set per instance through the parameters.
//
// Features:
//   - valid/ready handshake on both sides
//   - optional 2-entry skid buffer (macro PIPE_STAGE_SKID_EN)
//   - synchronous flush that turns every held beat into a bubble
//   - sticky halt tracker (hlt_seen)
//   - saturating back-pressure cycle counter (stall_cnt)
//
// Handshake: a beat moves whenever valid and ready are both high at the rising
// clock edge. Upstream may change its beat only after it has been taken.
// Downstream sees a stable beat on out_* for as long as out_valid=1 and
// out_ready=0.
//
// Configuration:
//   PIPE_STAGE_SKID_EN defined   : main entry M plus skid entry S; in_ready is
//                                  a flop output, so no combinational path
//                                  runs from out_ready to in_ready.
//   PIPE_STAGE_SKID_EN undefined : main entry M only; in_ready is
//                                  combinational from out_ready. Throughput
//                                  is still one beat per cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream beat valid
//   in_ready   out  stage can accept a beat
//   in_ctrl    in   [CTRL_W] control bits of the beat
//   in_data0   in   [DATA_W] data field 0
//   in_data1   in   [DATA_W] data field 1
//   in_waddr   in   [ADDR_W] destination register address
//   in_hlt     in   beat carries a halt instruction
//   flush      in   squash all held beats (synchronous)
//   out_valid  out  downstream beat valid
//   out_ready  in   downstream accepts the beat
//   out_ctrl   out  [CTRL_W] control bits, zero when out_valid=0
//   out_data0  out  [DATA_W] data field 0 (holds while out_valid=0)
//   out_data1  out  [DATA_W] data field 1 (holds while out_valid=0)
//   out_waddr  out  [ADDR_W] destination address (holds while out_valid=0)
//   out_hlt    out  head beat carries halt, zero when out_valid=0
//   hlt_seen   out  sticky: a halt beat has left through the output
//   stall_cnt  out  [CNT_W] saturating count of out_valid & ~out_ready cycles
// -----------------------------------------------------------------------------
module pipe_stage_regs #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic              in_hlt,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [ADDR_W-1:0] out_waddr,
    output logic              out_hlt,

    output logic              hlt_seen,
    output logic [CNT_W-1:0]  stall_cnt
);

    // -------------------------------------------------------------------------
    // Beat layout inside one storage entry (LSB first):
    //   data0 | data1 | waddr | ctrl | hlt
    // -------------------------------------------------------------------------
    localparam int D0_LSB = 0;
    localparam int D1_LSB = D0_LSB + DATA_W;
    localparam int WA_LSB = D1_LSB + DATA_W;
    localparam int CT_LSB = WA_LSB + ADDR_W;
    localparam int HL_BIT = CT_LSB + CTRL_W;
    localparam int BEAT_W = HL_BIT + 1;

    // Flush keeps the data fields and address but wipes ctrl and hlt, so a
    // squashed entry can never write a register or raise a halt later.
    localparam logic [BEAT_W-1:0] FLUSH_KEEP =
        {1'b0, {CTRL_W{1'b0}}, {(ADDR_W + 2*DATA_W){1'b1}}};

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // -------------------------------------------------------------------------
    // Storage and next-state signals
    // -------------------------------------------------------------------------
    logic              r_m_valid;
    logic [BEAT_W-1:0] r_m_beat;
    logic              r_hlt_seen;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_m_valid_nxt;
    logic [BEAT_W-1:0] w_m_beat_nxt;
    logic              w_hlt_seen_nxt;
    logic [CNT_W-1:0]  w_stall_cnt_nxt;

    logic [BEAT_W-1:0] w_in_beat;
    logic              w_up;
    logic              w_down;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_s_valid;
    logic [BEAT_W-1:0] r_s_beat;
    logic              r_in_ready;

    logic              w_s_valid_nxt;
    logic [BEAT_W-1:0] w_s_beat_nxt;
`endif

    assign w_in_beat = {in_hlt, in_ctrl, in_waddr, in_data1, in_data0};

    // -------------------------------------------------------------------------
    // Handshake terms
    // -------------------------------------------------------------------------
`ifdef PIPE_STAGE_SKID_EN
    // Registered ready: low exactly when the skid entry is occupied or a halt
    // has already gone downstream.
    assign in_ready = r_in_ready;
`else
    // Single-entry stage: take a beat when M is empty or is being emptied in
    // this same cycle.
    assign in_ready = (~r_m_valid | out_ready) & ~r_hlt_seen;
`endif

    assign w_up   = in_valid & in_ready;
    assign w_down = r_m_valid & out_ready;

    // -------------------------------------------------------------------------
    // Entry next-state
    // -------------------------------------------------------------------------
    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_m_beat_nxt  = r_m_beat;
`ifdef PIPE_STAGE_SKID_EN
        w_s_valid_nxt = r_s_valid;
        w_s_beat_nxt  = r_s_beat;

        if (flush) begin
            // Flush beats any upstream transfer; the incoming beat is dropped.
            w_m_valid_nxt = 1'b0;
            w_m_beat_nxt  = r_m_beat & FLUSH_KEEP;
            w_s_valid_nxt = 1'b0;
            w_s_beat_nxt  = r_s_beat & FLUSH_KEEP;
        end else if (!r_m_valid || w_down) begin
            // M is free for the next beat: the oldest held beat moves up.
            if (r_s_valid) begin
                w_m_valid_nxt = 1'b1;
                w_m_beat_nxt  = r_s_beat;
                // in_ready is low while S is valid, so w_up is normally 0
                // here; the refill keeps ordering intact regardless.
                w_s_valid_nxt = w_up;
                if (w_up) begin
                    w_s_beat_nxt = w_in_beat;
                end
            end else if (w_up) begin
                w_m_valid_nxt = 1'b1;
                w_m_beat_nxt  = w_in_beat;
            end else begin
                // Drained: only the valid bit drops, data fields hold.
                w_m_valid_nxt = 1'b0;
            end
        end else if (w_up) begin
            // M is stuck behind back-pressure; park the beat in S.
            w_s_valid_nxt = 1'b1;
            w_s_beat_nxt  = w_in_beat;
        end
`else
        if (flush) begin
            w_m_valid_nxt = 1'b0;
            w_m_beat_nxt  = r_m_beat & FLUSH_KEEP;
        end else if (w_up) begin
            // in_ready guarantees M is empty or leaving this cycle.
            w_m_valid_nxt = 1'b1;
            w_m_beat_nxt  = w_in_beat;
        end else if (w_down) begin
            w_m_valid_nxt = 1'b0;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Halt tracker and stall counter
    // -------------------------------------------------------------------------
    always_comb begin
        // A halt that leaves in the same cycle as a flush still counts, since
        // the downstream transfer itself is completed.
        w_hlt_seen_nxt = r_hlt_seen | (w_down & r_m_beat[HL_BIT]);

        w_stall_cnt_nxt = r_stall_cnt;
        if (r_m_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
            w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid   <= 1'b0;
            r_m_beat    <= '0;
            r_hlt_seen  <= 1'b0;
            r_stall_cnt <= '0;
`ifdef PIPE_STAGE_SKID_EN
            r_s_valid   <= 1'b0;
            r_s_beat    <= '0;
            r_in_ready  <= 1'b1;
`endif
        end else begin
            r_m_valid   <= w_m_valid_nxt;
            r_m_beat    <= w_m_beat_nxt;
            r_hlt_seen  <= w_hlt_seen_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
`ifdef PIPE_STAGE_SKID_EN
            r_s_valid   <= w_s_valid_nxt;
            r_s_beat    <= w_s_beat_nxt;
            r_in_ready  <= ~w_s_valid_nxt & ~w_hlt_seen_nxt;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: everything comes straight from M; ctrl and hlt are gated so a
    // bubble carries no side effects downstream.
    // -------------------------------------------------------------------------
    assign out_valid = r_m_valid;
    assign out_ctrl  = r_m_valid ? r_m_beat[CT_LSB +: CTRL_W] : '0;
    assign out_hlt   = r_m_valid & r_m_beat[HL_BIT];
    assign out_data0 = r_m_beat[D0_LSB +: DATA_W];
    assign out_data1 = r_m_beat[D1_LSB +: DATA_W];
    assign out_waddr = r_m_beat[WA_LSB +: ADDR_W];
    assign hlt_seen  = r_hlt_seen;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_regs
//
// Self-checking bench for pipe_stage_regs. The reference model is a FIFO of
// held beats with capacity 2 (skid build) or 1 (single-entry build), a sticky
// halt flag and two saturating counters (CNT_W=8 main instance and a CNT_W=4
// instance driven by the same stimulus).
// -----------------------------------------------------------------------------
module tb_pipe_stage_regs;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 8;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 8;
    localparam int CNT4_W = 4;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
    localparam int CAP  = 2;
`else
    localparam bit SKID = 1'b0;
    localparam int CAP  = 1;
`endif

    typedef struct packed {
        logic              hlt;
        logic [CTRL_W-1:0] ctrl;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d0;
    } beat_t;

    localparam int BW = $bits(beat_t);

    // ---------------------------------------------------------------- signals
    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data0;
    logic [DATA_W-1:0] in_data1;
    logic [ADDR_W-1:0] in_waddr;
    logic              in_hlt;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;
    logic [ADDR_W-1:0] out_waddr;
    logic              out_hlt;
    logic              hlt_seen;
    logic [CNT_W-1:0]  stall_cnt;

    logic              o4_in_ready;
    logic              o4_valid;
    logic [CTRL_W-1:0] o4_ctrl;
    logic [DATA_W-1:0] o4_data0;
    logic [DATA_W-1:0] o4_data1;
    logic [ADDR_W-1:0] o4_waddr;
    logic              o4_hlt;
    logic              o4_hlt_seen;
    logic [CNT4_W-1:0] o4_stall_cnt;

    // ------------------------------------------------------------ scoreboard
    logic [BW-1:0] exp_q[$];
    beat_t         m_last;
    bit            m_hlt;
    int unsigned   m_cnt;
    int unsigned   m_cnt4;
    int            n_sent;

    int errors = 0;
    int checks = 0;

    // ------------------------------------------------------------------- DUTs
    pipe_stage_regs #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_data0(in_data0), .in_data1(in_data1), .in_waddr(in_waddr),
        .in_hlt(in_hlt), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data0(out_data0), .out_data1(out_data1), .out_waddr(out_waddr),
        .out_hlt(out_hlt), .hlt_seen(hlt_seen), .stall_cnt(stall_cnt)
    );

    pipe_stage_regs #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .CNT_W(CNT4_W)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(o4_in_ready), .in_ctrl(in_ctrl),
        .in_data0(in_data0), .in_data1(in_data1), .in_waddr(in_waddr),
        .in_hlt(in_hlt), .flush(flush),
        .out_valid(o4_valid), .out_ready(out_ready), .out_ctrl(o4_ctrl),
        .out_data0(o4_data0), .out_data1(o4_data1), .out_waddr(o4_waddr),
        .out_hlt(o4_hlt), .hlt_seen(o4_hlt_seen), .stall_cnt(o4_stall_cnt)
    );

    // ------------------------------------------------------- clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ----------------------------------------------------------------- model
    function automatic bit model_in_ready(input bit ordy);
        return !m_hlt && ((exp_q.size() < CAP) || (!SKID && ordy));
    endfunction

    function automatic beat_t exp_head();
        if (exp_q.size() > 0) begin
            return beat_t'(exp_q[0]);
        end
        return m_last;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_last = '0;
        m_hlt  = 1'b0;
        m_cnt  = 0;
        m_cnt4 = 0;
        n_sent = 0;
    endtask

    // Applies the current inputs to the model, then clocks the DUT. Entered
    // and left at a falling edge.
    task automatic step();
        bit    rdy;
        bit    up;
        bit    down;
        beat_t hd;
        beat_t nb;
        rdy  = model_in_ready(out_ready);
        up   = in_valid && rdy;
        down = (exp_q.size() > 0) && out_ready;
        if ((exp_q.size() > 0) && !out_ready) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (down) begin
            hd = beat_t'(exp_q.pop_front());
            if (hd.hlt) m_hlt = 1'b1;
        end
        if (flush) begin
            exp_q.delete();
        end else if (up) begin
            nb.hlt   = in_hlt;
            nb.ctrl  = in_ctrl;
            nb.waddr = in_waddr;
            nb.d1    = in_data1;
            nb.d0    = in_data0;
            exp_q.push_back(nb);
            n_sent++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) m_last = beat_t'(exp_q[0]);
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- driver
    task automatic drive(input bit v, input logic [DATA_W-1:0] d0,
                         input logic [CTRL_W-1:0] ctrl, input bit hlt,
                         input bit fl, input bit ordy);
        in_valid  = v;
        in_data0  = d0;
        in_data1  = DATA_W'($urandom);
        in_ctrl   = ctrl;
        in_waddr  = ADDR_W'($urandom_range(0, 15));
        in_hlt    = hlt;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL reset_out_ctrl got=%h exp=00", out_ctrl); end
        checks++; if ({out_data0, out_data1, out_waddr} !== '0) begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", out_data0, out_data1, out_waddr); end
        checks++; if ({out_hlt, hlt_seen} !== 2'b00) begin errors++; $display("FAIL reset_hlt got=%b exp=00", {out_hlt, hlt_seen}); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (o4_stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt4 got=%0d exp=0", o4_stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL reset_release got=%b exp=01", {out_valid, in_ready}); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DATA_W'(i), 8'h11, 1'b0, 1'b0, 1'b1);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat=%0d got=%0b exp=1", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_out_valid beat=%0d got=%0b exp=1", i, out_valid); end
            checks++; if (out_data0 !== DATA_W'(i)) begin errors++; $display("FAIL stream_data0 beat=%0d got=%h exp=%h", i, out_data0, DATA_W'(i)); end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data0 !== 16'h0004) begin errors++; $display("FAIL stream_data_hold got=%h exp=0004", out_data0); end
        checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL stream_ctrl_gate got=%h exp=00", out_ctrl); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        drive(1'b1, 16'hAAAA, 8'h21, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (out_data0 !== 16'hAAAA) begin errors++; $display("FAIL bp_first got=%h exp=AAAA", out_data0); end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 16'hBBBB, 8'h22, 1'b0, 1'b0, 1'b0);
            step();
        end
        checks++; if (stall_cnt !== 8'd3) begin errors++; $display("FAIL bp_stall_cnt got=%0d exp=3", stall_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
        checks++; if ({out_valid, out_data0} !== {1'b1, 16'hAAAA}) begin errors++; $display("FAIL bp_hold got=%b/%h exp=1/AAAA", out_valid, out_data0); end
        // Keep offering 0xBBBB only while the stage has not taken it yet.
        drive(n_sent < 2, 16'hBBBB, 8'h22, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if ({out_valid, out_data0} !== {1'b1, 16'hBBBB}) begin errors++; $display("FAIL bp_second got=%b/%h exp=1/BBBB", out_valid, out_data0); end
        checks++; if (stall_cnt !== 8'd3) begin errors++; $display("FAIL bp_cnt_kept got=%0d exp=3", stall_cnt); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_drained got=%b exp=01", {out_valid, in_ready}); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 16'hC001, 8'h31, 1'b0, 1'b0, 1'b0);
        step();
        if (SKID) begin
            drive(1'b1, 16'hC002, 8'h32, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 16'hC003, 8'hFF, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL flush_ctrl got=%h exp=00", out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_data0 !== 16'hC001) begin errors++; $display("FAIL flush_data_hold got=%h exp=C001", out_data0); end
        checks++; if (stall_cnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL flush_stall_cnt got=%0d exp=%0d", stall_cnt, m_cnt); end
        // Flush with an empty stage and a live upstream beat: beat is dropped.
        drive(1'b1, 16'hC004, 8'hFF, 1'b0, 1'b1, 1'b1);
        step();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost cyc=%0d got=%0b exp=0", c, out_valid); end
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive(1'b1, 16'h0100, 8'h41, 1'b1, 1'b0, 1'b1);
        step();
        checks++; if ({out_valid, out_hlt, hlt_seen} !== 3'b110) begin errors++; $display("FAIL halt_head got=%b exp=110", {out_valid, out_hlt, hlt_seen}); end
        drive(1'b1, 16'h0200, 8'h42, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (hlt_seen !== 1'b1) begin errors++; $display("FAIL halt_seen got=%0b exp=1", hlt_seen); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready got=%0b exp=0", in_ready); end
        checks++; if ({out_valid, out_hlt, out_data0} !== {2'b10, 16'h0200}) begin errors++; $display("FAIL halt_drain got=%b/%b/%h exp=1/0/0200", out_valid, out_hlt, out_data0); end
        drive(1'b1, 16'h0300, 8'h43, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL halt_blocked got=%b exp=00", {out_valid, in_ready}); end
        drive(1'b1, 16'h0400, 8'h44, 1'b0, 1'b1, 1'b1);
        step();
        checks++; if ({in_ready, hlt_seen} !== 2'b01) begin errors++; $display("FAIL halt_after_flush got=%b exp=01", {in_ready, hlt_seen}); end
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 16'h0500, 8'h45, 1'b0, 1'b0, 1'b1);
            step();
            checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL halt_stays cyc=%0d got=%b exp=00", c, {out_valid, in_ready}); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, 16'h5A5A, 8'h51, 1'b0, 1'b0, 1'b0);
        step();
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
            step();
        end
        checks++; if (o4_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat4_at_20 got=%0d exp=15", o4_stall_cnt); end
        checks++; if (stall_cnt !== 8'd20) begin errors++; $display("FAIL sat8_at_20 got=%0d exp=20", stall_cnt); end
        checks++; if ({out_valid, out_data0} !== {1'b1, 16'h5A5A}) begin errors++; $display("FAIL sat_hold got=%b/%h exp=1/5A5A", out_valid, out_data0); end
        for (int c = 0; c < 240; c++) begin
            step();
        end
        checks++; if (stall_cnt !== 8'd255) begin errors++; $display("FAIL sat8_at_260 got=%0d exp=255", stall_cnt); end
        for (int c = 0; c < 5; c++) begin
            step();
        end
        checks++; if ({stall_cnt, o4_stall_cnt} !== {8'd255, 4'd15}) begin errors++; $display("FAIL sat_no_wrap got=%0d/%0d exp=255/15", stall_cnt, o4_stall_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 16'hD001, 8'h61, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'hD002, 8'h62, 1'b0, 1'b0, 1'b0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%0b exp=0", out_valid); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL areset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%0b exp=1", in_ready); end
        checks++; if ({out_ctrl, o4_stall_cnt, o4_valid} !== '0) begin errors++; $display("FAIL areset_misc got=%h/%0d/%0b exp=0", out_ctrl, o4_stall_cnt, o4_valid); end
        model_clear();
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random(input int n_cyc, input int hlt_pct);
        beat_t             hd;
        bit                ev;
        bit                er;
        logic [CTRL_W-1:0] ec;
        bit                eh;
        for (int i = 0; i < n_cyc; i++) begin
            drive($urandom_range(0, 99) < 70, DATA_W'($urandom), CTRL_W'($urandom),
                  $urandom_range(0, 99) < hlt_pct, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 60);
            #1;
            er = model_in_ready(out_ready);
            checks++; if (in_ready !== er) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", i, in_ready, er); end
            step();
            hd = exp_head();
            ev = exp_q.size() > 0;
            ec = ev ? hd.ctrl : '0;
            eh = ev & hd.hlt;
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%0b exp=%0b", i, out_valid, ev); end
            checks++; if (out_ctrl !== ec) begin errors++; $display("FAIL rnd_out_ctrl cyc=%0d got=%h exp=%h", i, out_ctrl, ec); end
            checks++; if ({out_data0, out_data1, out_waddr} !== {hd.d0, hd.d1, hd.waddr}) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h/%h/%h exp=%h/%h/%h", i, out_data0, out_data1, out_waddr, hd.d0, hd.d1, hd.waddr); end
            checks++; if ({out_hlt, hlt_seen} !== {eh, m_hlt}) begin errors++; $display("FAIL rnd_hlt cyc=%0d got=%b exp=%b", i, {out_hlt, hlt_seen}, {eh, m_hlt}); end
            checks++; if (stall_cnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, m_cnt); end
            checks++; if ({o4_valid, o4_ctrl, o4_data0, o4_data1, o4_waddr, o4_hlt, o4_hlt_seen, o4_stall_cnt, o4_in_ready}
                          !== {ev, ec, hd.d0, hd.d1, hd.waddr, eh, m_hlt, CNT4_W'(m_cnt4), model_in_ready(out_ready)}) begin
                errors++; $display("FAIL rnd_dut4 cyc=%0d valid=%0b cnt=%0d exp_valid=%0b exp_cnt=%0d", i, o4_valid, o4_stall_cnt, ev, m_cnt4);
            end
        end
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        model_clear();
        @(negedge clk);
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random(400, 0);
        do_reset();
        test_random(150, 3);
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
